pc_sequencer: RTL and testbench

Parametrised next-generation program counter for the pipelined CPU's fetch stage. Selects the next PC from these sources:
- sequential
- PC-relative branch
- region jump
- register jump
- call and return, with a hardware return-address stack (RAS)
- exception vector and exception return, with an EPC register

Sits between the decode/execute control outputs and the instruction memory address port.

---
 rtl/pc_pkg.sv | 16 +
 rtl/return_stack.sv | 57 +++++
 rtl/pc_sequencer.sv | 105 ++++++++++
 tb/tb_pc_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - next-PC source encoding and fetch constants
package pc_pkg;

    typedef enum logic [2:0] {
        SEQ    = 3'd0,
        BRANCH = 3'd1,
        JUMP   = 3'd2,
        JREG   = 3'd3,
        CALL   = 3'd4,
        RET    = 3'd5,
        ERET   = 3'd6
    } pc_src_e;

    localparam int INST_BYTES = 4;

endpackage

// File: rtl/return_stack.sv
// rtl/return_stack.sv - circular return-address stack with top pointer and count
module return_stack #(
    parameter int BITS  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [BITS-1:0] wdata,
    output logic [BITS-1:0] top,
    output logic            empty,
    output logic            full,
    output logic            overflow_evt,
    output logic            underflow_evt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [BITS-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] top_ptr;
    logic [PTR_W-1:0] push_ptr;
    logic [CNT_W-1:0] count;

    assign push_ptr      = top_ptr + PTR_W'(1);
    assign empty         = (count == '0);
    assign full          = (count == CNT_W'(DEPTH));
    assign top           = mem[top_ptr];
    assign overflow_evt  = push && full;
    assign underflow_evt = pop && empty;

    // A push onto a full stack advances the pointer over the oldest entry,
    // so the circular buffer silently discards it while count saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            top_ptr <= '0;
            count   <= '0;
        end else if (push) begin
            top_ptr <= push_ptr;
            if (!full) begin
                count <= count + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            top_ptr <= top_ptr - PTR_W'(1);
            count   <= count - CNT_W'(1);
        end
    end

    // Entry contents need no reset; count alone decides validity.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[push_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch-stage next-PC selection with return stack and exception PC
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int              BITS        = 32,
    parameter logic [BITS-1:0] RESET_PC    = '0,
    parameter logic [BITS-1:0] EXC_VECTOR  = BITS'(32'h0000_0080),
    parameter int              REGION_BITS = 4,
    parameter int              RAS_DEPTH   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            exc,
    input  logic [2:0]      pc_source,
    input  logic [BITS-1:0] offset,
    input  logic [BITS-1:0] absolute,
    output logic [BITS-1:0] pc,
    output logic [BITS-1:0] epc,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            ras_overflow,
    output logic            ras_underflow
);

    logic [BITS-1:0] pc_next;
    logic [BITS-1:0] epc_next;
    logic [BITS-1:0] seq_target;
    logic [BITS-1:0] branch_target;
    logic [BITS-1:0] jump_target;
    logic [BITS-1:0] reg_target;
    logic [BITS-1:0] ras_top;
    logic            advance;
    logic            ras_push;
    logic            ras_pop;
    logic            ras_overflow_evt;
    logic            ras_underflow_evt;
    logic            unused_bits;

    // pc already points past the control instruction, so it is both the
    // base for relative branches and the link address for calls.
    assign seq_target    = pc + BITS'(INST_BYTES);
    assign branch_target = pc + {offset[BITS-3:0], 2'b00};
    assign jump_target   = {pc[BITS-1:BITS-REGION_BITS], absolute[BITS-REGION_BITS-1:0]};
    assign reg_target    = {absolute[BITS-1:2], 2'b00};
    assign unused_bits   = ^{offset[BITS-1:BITS-2], absolute[1:0]};

    assign advance  = !exc && !stall;
    assign ras_push = advance && (pc_source == CALL);
    assign ras_pop  = advance && (pc_source == RET);

    return_stack #(
        .BITS  (BITS),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk           (clk),
        .rst           (rst),
        .push          (ras_push),
        .pop           (ras_pop),
        .wdata         (pc),
        .top           (ras_top),
        .empty         (ras_empty),
        .full          (ras_full),
        .overflow_evt  (ras_overflow_evt),
        .underflow_evt (ras_underflow_evt)
    );

    always_comb begin
        pc_next  = pc;
        epc_next = epc;
        if (exc) begin
            epc_next = pc;
            pc_next  = EXC_VECTOR;
        end else if (!stall) begin
            case (pc_source)
                BRANCH:  pc_next = branch_target;
                JUMP:    pc_next = jump_target;
                JREG:    pc_next = reg_target;
                CALL:    pc_next = jump_target;
                RET:     pc_next = ras_empty ? reg_target : ras_top;
                ERET:    pc_next = epc;
                default: pc_next = seq_target;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc            <= RESET_PC;
            epc           <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            pc  <= pc_next;
            epc <= epc_next;
            if (ras_overflow_evt) begin
                ras_overflow <= 1'b1;
            end
            if (ras_underflow_evt) begin
                ras_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed vector table plus randomized reference-model check of pc_sequencer
module tb_pc_sequencer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        exc;
    logic [2:0]  pc_source;
    logic [31:0] offset;
    logic [31:0] absolute;
    logic [31:0] pc;
    logic [31:0] epc;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_overflow;
    logic        ras_underflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .exc           (exc),
        .pc_source     (pc_source),
        .offset        (offset),
        .absolute      (absolute),
        .pc            (pc),
        .epc           (epc),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    typedef struct {
        logic        r;
        logic        e;
        logic        s;
        logic [2:0]  src;
        logic [31:0] off;
        logic [31:0] abs_v;
        logic [31:0] x_pc;
        logic [31:0] x_epc;
        logic        x_emp;
        logic        x_full;
        logic        x_ov;
        logic        x_un;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic e, logic s, logic [2:0] src,
                                logic [31:0] off, logic [31:0] abs_v,
                                logic [31:0] x_pc, logic [31:0] x_epc,
                                logic x_emp, logic x_full, logic x_ov, logic x_un);
        vec_t v;
        v.r = r; v.e = e; v.s = s; v.src = src; v.off = off; v.abs_v = abs_v;
        v.x_pc = x_pc; v.x_epc = x_epc; v.x_emp = x_emp; v.x_full = x_full;
        v.x_ov = x_ov; v.x_un = x_un;
        return v;
    endfunction

    task automatic check32(string name, logic [31:0] act, logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp_v);
        end
    endtask

    task automatic check1(string name, logic act, logic exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp_v);
        end
    endtask

    task automatic step(logic r, logic e, logic s, logic [2:0] src,
                        logic [31:0] off, logic [31:0] abs_v);
        rst = r; exc = e; stall = s; pc_source = src; offset = off; absolute = abs_v;
        @(posedge clk);
        #1;
    endtask

    // Reference model: return stack kept as a queue, newest at the back.
    logic [31:0] m_pc;
    logic [31:0] m_epc;
    logic        m_ov;
    logic        m_un;
    logic [31:0] m_ras[$];

    task automatic model_step(logic r, logic e, logic s, logic [2:0] src,
                              logic [31:0] off, logic [31:0] abs_v);
        logic [31:0] old_pc;
        logic [31:0] jmp;
        old_pc = m_pc;
        jmp    = (old_pc & 32'hF000_0000) | (abs_v & 32'h0FFF_FFFF);
        if (r) begin
            m_pc = 32'h0; m_epc = 32'h0; m_ov = 1'b0; m_un = 1'b0;
            m_ras.delete();
        end else if (e) begin
            m_epc = old_pc;
            m_pc  = 32'h80;
        end else if (!s) begin
            case (src)
                3'd1: m_pc = old_pc + off * 32'd4;
                3'd2: m_pc = jmp;
                3'd3: m_pc = abs_v & ~32'h3;
                3'd4: begin
                    m_pc = jmp;
                    if (m_ras.size() == DEPTH) begin
                        void'(m_ras.pop_front());
                        m_ov = 1'b1;
                    end
                    m_ras.push_back(old_pc);
                end
                3'd5: begin
                    if (m_ras.size() > 0) begin
                        m_pc = m_ras.pop_back();
                    end else begin
                        m_pc = abs_v & ~32'h3;
                        m_un = 1'b1;
                    end
                end
                3'd6: m_pc = m_epc;
                default: m_pc = old_pc + 32'd4;
            endcase
        end
    endtask

    initial begin
        rst = 1'b1; exc = 1'b0; stall = 1'b0; pc_source = 3'd0; offset = '0; absolute = '0;

        //                r  e  s  src offset        absolute       pc             epc           emp full ov un
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,        32'h0,         32'h0,         32'h0,        1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,        32'h0,         32'h0,         32'h0,        1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,         32'h4,         32'h0,        1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,         32'h8,         32'h0,        1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,         32'hC,         32'h0,        1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 3, 32'h0,        32'h103,       32'h100,       32'h0,        1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 32'hFFFF_FFFE, 32'h0,        32'hF8,        32'h0,        1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 3, 32'h0,        32'hF000_0010, 32'hF000_0010, 32'h0,        1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 2, 32'h0,        32'h0123_4568, 32'hF123_4568, 32'h0,        1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 3, 32'h0,        32'h200,       32'h200,       32'h0,        1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 4, 32'h0,        32'h400,       32'h400,       32'h0,        0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,         32'h404,       32'h0,        0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 5, 32'h0,        32'h0,         32'h200,       32'h0,        1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 4, 32'h0,        32'h1000,      32'h1000,      32'h0,        0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 4, 32'h0,        32'h2000,      32'h2000,      32'h0,        0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 4, 32'h0,        32'h3000,      32'h3000,      32'h0,        0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 4, 32'h0,        32'h4000,      32'h4000,      32'h0,        0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 4, 32'h0,        32'h5000,      32'h5000,      32'h0,        0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 5, 32'h0,        32'h0,         32'h4000,      32'h0,        0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 5, 32'h0,        32'h0,         32'h3000,      32'h0,        0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 5, 32'h0,        32'h0,         32'h2000,      32'h0,        0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 5, 32'h0,        32'h0,         32'h1000,      32'h0,        1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 5, 32'h0,        32'h777,       32'h774,       32'h0,        1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 3, 32'h0,        32'h300,       32'h300,       32'h0,        1, 0, 1, 1));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,        32'h0,         32'h80,        32'h300,      1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,        32'h0,         32'h80,        32'h300,      1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,        32'h0,         32'h80,        32'h300,      1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 6, 32'h0,        32'h0,         32'h300,       32'h300,      1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 4, 32'h0,        32'h10,        32'h10,        32'h300,      0, 0, 1, 1));
        vecs.push_back(mk(1, 0, 0, 5, 32'h0,        32'h0,         32'h0,         32'h0,        1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 5, 32'h0,        32'h55,        32'h54,        32'h0,        1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 4, 32'h0,        32'h999,       32'h54,        32'h0,        1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 4, 32'h0,        32'h999,       32'h80,        32'h54,       1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 7, 32'h0,        32'h0,         32'h84,        32'h54,       1, 0, 0, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].r, vecs[i].e, vecs[i].s, vecs[i].src, vecs[i].off, vecs[i].abs_v);
            check32($sformatf("vec%0d_pc", i), pc, vecs[i].x_pc);
            check32($sformatf("vec%0d_epc", i), epc, vecs[i].x_epc);
            check1($sformatf("vec%0d_empty", i), ras_empty, vecs[i].x_emp);
            check1($sformatf("vec%0d_full", i), ras_full, vecs[i].x_full);
            check1($sformatf("vec%0d_overflow", i), ras_overflow, vecs[i].x_ov);
            check1($sformatf("vec%0d_underflow", i), ras_underflow, vecs[i].x_un);
        end

        // Randomized phase: begins with a reset so model and DUT agree.
        model_step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            logic        r_r;
            logic        r_e;
            logic        r_s;
            logic [2:0]  r_src;
            logic [31:0] r_off;
            logic [31:0] r_abs;
            r_r   = ($urandom_range(0, 63) == 0);
            r_e   = ($urandom_range(0, 15) == 0);
            r_s   = ($urandom_range(0, 7) == 0);
            // Bias toward calls and returns so the stack fills and drains.
            r_src = ($urandom_range(0, 1) == 0) ? 3'($urandom_range(4, 5)) : 3'($urandom_range(0, 7));
            r_off = $urandom();
            r_abs = $urandom();
            model_step(r_r, r_e, r_s, r_src, r_off, r_abs);
            step(r_r, r_e, r_s, r_src, r_off, r_abs);
            check32($sformatf("rnd%0d_pc", n), pc, m_pc);
            check32($sformatf("rnd%0d_epc", n), epc, m_epc);
            check1($sformatf("rnd%0d_empty", n), ras_empty, m_ras.size() == 0);
            check1($sformatf("rnd%0d_full", n), ras_full, m_ras.size() == DEPTH);
            check1($sformatf("rnd%0d_overflow", n), ras_overflow, m_ov);
            check1($sformatf("rnd%0d_underflow", n), ras_underflow, m_un);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
